mux_skid_stage: RTL

Parametrised N-input selecting pipeline stage for the P5 datapath. It generalises the 32-bit 2:1 select into NUM_IN inputs of WIDTH bits. The selected word is registered behind a valid/ready handshake with a 2-entry skid buffer, so stall back-pressure is absorbed without combinational ready paths. It also adds flush and out-of-range-select detection. It sits between a forwarding source select and the next pipeline register.

---
 rtl/p5_pkg.sv | 15 +
 rtl/mux_skid_stage_mux_n.sv | 27 ++
 rtl/mux_skid_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/p5_pkg.sv
// Shared P5 datapath definitions: skid-stage state encoding and a width helper.
package p5_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // A 1-bit select is still needed when NUM_IN is 1 or 2.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_skid_stage_mux_n.sv
// Combinational N:1 word select; an out-of-range select yields zero and raises o_oor.
module mux_n
  import p5_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 2,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_oor
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_data = '0;
    o_oor  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_data[k*WIDTH +: WIDTH];
        o_oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_skid_stage.sv
// N-input selecting pipeline stage with a 2-entry skid buffer, flush and bad-select pulse.
module mux_skid_stage
  import p5_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 2,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  skid_state_e      r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_word;
  logic             w_oor;
  logic             w_accept;
  logic             w_pop;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_word),
    .o_oor  (w_oor)
  );

  assign w_accept = in_valid && r_in_ready;
  assign w_pop    = r_out_valid && out_ready;

  // Ready and valid are kept as their own flops, updated alongside the state,
  // so neither output has a combinational path from the handshake inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: both data entries are reset too, so out_data reads zero out of reset.
      r_state     <= SKID_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch reads pre-edge values.
      r_sel_err <= w_accept && w_oor;
      if (flush) begin
        r_state     <= SKID_EMPTY;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
      end else begin
        unique case (r_state)
          SKID_EMPTY: begin
            if (w_accept) begin
              r_main      <= w_word;
              r_state     <= SKID_ONE;
              r_out_valid <= 1'b1;
            end
          end
          SKID_ONE: begin
            if (w_accept && !w_pop) begin
              r_skid     <= w_word;
              r_state    <= SKID_FULL;
              r_in_ready <= 1'b0;
            end else if (w_accept) begin
              r_main <= w_word;
            end else if (w_pop) begin
              r_state     <= SKID_EMPTY;
              r_out_valid <= 1'b0;
            end
          end
          SKID_FULL: begin
            if (w_pop) begin
              r_main     <= r_skid;
              r_state    <= SKID_ONE;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign sel_err   = r_sel_err;

endmodule
